clk_div_ctrl: RTL
=================

// Module: clk_div_ctrl
// PURPOSE
//  Run-time programmable clock-enable generator and controller for the divider path.
//  Produces a 1-cycle tick strobe and a square wave clk_out from clk, using a loadable divisor.
//  New divisors are accepted through a valid/ready handshake and take effect only at a
//  half-period boundary, so clk_out never glitches. Sits between the register/config logic and
//  the slow-rate consumers.
// PARAMETERS
//  DIV_W        8   width of divisor and internal counter
//  DEFAULT_DIV  2   divisor loaded at reset; half-period = DIV+1 clk cycles
//  CNT_W        16  width of tick_count (only with CLKDIV_TICK_COUNT_EN)
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst        in   1      asynchronous, active-high reset
//  en         in   1      run request; level-sensitive
//  cfg_valid  in   1      new divisor offered
//  cfg_div    in   DIV_W  divisor value; 0 is legal and gives divide-by-2
//  cfg_ready  out  1      divisor can be accepted this cycle
//  tick       out  1      1-cycle strobe at each half-period end
//  clk_out    out  1      square wave, period 2*(div_reg+1) cycles
//  busy       out  1      state != IDLE
//  tick_count out  CNT_W  ticks since reset; present only with CLKDIV_TICK_COUNT_EN
// BEHAVIOUR
//  Reset (async, immediate, also mid-run):
//   - state=IDLE, count=0, div_reg=DEFAULT_DIV, pend_reg=0.
//   - clk_out=0, tick=0, cfg_ready=1, busy=0, tick_count=0.
//  Registers and outputs:
//   - All outputs are registered except cfg_ready and busy, which decode directly from state.
//   - Terminal count (TC) means state!=IDLE && count==div_reg.
//  States and transitions:
//   - IDLE: count held at 0, clk_out=0, cfg_ready=1.
//     - An accepted cfg loads div_reg next cycle.
//     - en=1 -> RUN; counting starts at 0 on the next cycle.
//     - If a cfg accept and en=1 occur in the same cycle, the run uses the new cfg_div.
//   - RUN: count increments by 1 each cycle. At TC:
//     - count<=0, tick<=1 for one cycle, clk_out<=~clk_out.
//     - cfg_ready=1; an accept stores cfg_div in pend_reg and moves to PENDING.
//   - PENDING: cfg_ready=0; counting continues with the old div_reg.
//     - At TC: div_reg<=pend_reg, count<=0, tick, toggle, then -> RUN.
//   - Stop with en=0 in RUN or PENDING:
//     - Counting continues until the first TC where clk_out==1.
//     - At that TC: tick fires, clk_out->0, state->IDLE.
//     - A TC with clk_out==0 toggles normally; the clock keeps running.
//     - A pending divisor is committed to div_reg at the stop TC.
//     - en re-asserted before the stop TC cancels the stop; no gap in clk_out.
//  Handshake: a transfer occurs when cfg_valid && cfg_ready; cfg_div is sampled that cycle.
//  Width/timing rules:
//   - The counter is DIV_W wide and never exceeds div_reg, so it cannot overflow.
//   - A tick appears 1 cycle after TC is reached (registered).
//   - First tick arrives div+1 cycles after the cycle RUN is entered.
// CONFIGURATION
//  CLKDIV_TICK_COUNT_EN defined:
//   - tick_count port exists; +1 on every tick; wraps 2^CNT_W-1 -> 0.
//   - Cleared only by rst; holds its value in IDLE.
//  Not defined: the port and its counter are absent.
// STRUCTURE
//  Shared include clk_div_pkg.vh holds:
//   - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PEND=2'd2 (2'd3 is illegal and recovers to IDLE).
//   - The DEFAULT_DIV default.
//  Sub-module div_core:
//   - Contains count, the TC compare, the tick and clk_out registers.
//   - Inputs: run, div_reg. Outputs: tc, tick, clk_out.
//  clk_div_ctrl itself holds the FSM, the handshake, pend_reg and the optional counter.
// TESTING
//  1 Reset then en=1, DEFAULT_DIV=2 -> tick every 3 cycles; clk_out period 6; busy=1.
//  2 In IDLE, cfg_div=0 accepted, then en=1 -> tick every cycle; clk_out toggles each cycle.
//  3 RUN div=4, cfg_div=1 accepted mid-half-period:
//     - cfg_ready=0 until the next TC.
//     - The old 5-cycle half-period completes; 2-cycle half-periods follow; no short pulse.
//  4 en=0 while clk_out=0, div=3:
//     - Runs 4 more cycles (clk_out->1), then 4 more to the stop TC.
//     - clk_out=0 and busy=0 after that; no further ticks.
//  5 Assert rst mid-RUN with clk_out=1:
//     - clk_out, tick and busy go to 0 immediately.
//     - After release, div_reg==DEFAULT_DIV.
//  6 With CLKDIV_TICK_COUNT_EN, CNT_W=4, div=0:
//     - tick_count goes 15 -> 0 on the 16th tick and holds after stop.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// rtl/clk_div_ctrl_pkg.sv - shared state encodings and defaults for the clock divider controller
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_ILL  = 2'd3
    } state_t;

    localparam int DEFAULT_DIV_P = 2;

endpackage

// File: rtl/clk_div_ctrl_div_core.sv
// rtl/clk_div_ctrl_div_core.sv - half-period counter, terminal-count compare, tick and clk_out registers
module div_core #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tc,
    output logic             o_tick,
    output logic             o_clk_out
);

    logic [DIV_W-1:0] r_count;

    assign o_tc = i_run && (r_count == i_div);

    // clk_out is forced low whenever not running so no stale level survives an FSM recovery
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count   <= '0;
            o_tick    <= 1'b0;
            o_clk_out <= 1'b0;
        end else if (!i_run) begin
            r_count   <= '0;
            o_tick    <= 1'b0;
            o_clk_out <= 1'b0;
        end else if (o_tc) begin
            r_count   <= '0;
            o_tick    <= 1'b1;
            o_clk_out <= ~o_clk_out;
        end else begin
            r_count   <= r_count + 1'b1;
            o_tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock-enable generator with glitch-free divisor reload
// Optional tick counter output enabled by CLKDIV_TICK_COUNT_EN.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = DEFAULT_DIV_P
`ifdef CLKDIV_TICK_COUNT_EN
    ,
    parameter int CNT_W       = 16
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_cfg_valid,
    input  logic [DIV_W-1:0] i_cfg_div,
    output logic             o_cfg_ready,
    output logic             o_tick,
    output logic             o_clk_out,
    output logic             o_busy
`ifdef CLKDIV_TICK_COUNT_EN
    ,
    output logic [CNT_W-1:0] o_tick_count
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] r_pend;
    logic [DIV_W-1:0] w_pend_nxt;
    logic             w_run;
    logic             w_tc;
    logic             w_accept;
    logic             w_stop;

    assign w_run       = (r_state == ST_RUN) || (r_state == ST_PEND);
    assign o_cfg_ready = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign o_busy      = (r_state != ST_IDLE);
    assign w_accept    = i_cfg_valid && o_cfg_ready;
    // Stopping is only allowed at the end of a high half-period
    assign w_stop      = w_tc && !i_en && o_clk_out;

    div_core #(
        .DIV_W (DIV_W)
    ) u_div_core (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_run     (w_run),
        .i_div     (r_div),
        .o_tc      (w_tc),
        .o_tick    (o_tick),
        .o_clk_out (o_clk_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_pend_nxt  = r_pend;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_div_nxt = i_cfg_div;
                if (i_en)     w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                    if (w_accept) w_div_nxt = i_cfg_div;
                end else if (w_accept) begin
                    w_pend_nxt  = i_cfg_div;
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_tc) begin
                    w_div_nxt   = r_pend;
                    w_state_nxt = w_stop ? ST_IDLE : ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_div   <= DIV_W'(DEFAULT_DIV);
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

`ifdef CLKDIV_TICK_COUNT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tick_count <= '0;
        end else if (o_tick) begin
            o_tick_count <= o_tick_count + CNT_W'(1);
        end
    end
`endif

endmodule
